// File: rtl/regfile_writeback.sv
// regfile_writeback
// -----------------
// Write-back stage between the execution units and the architectural
// register file. ALU and load-unit results are merged into a small
// circular write queue. The oldest queued write is issued to the register
// file port on every cycle the queue is non-empty, so a result reaches
// the register file one edge after it is accepted.
//
// The block also tracks in-flight destination registers (busy_mask) and
// answers a combinational forwarding query (fwd_rs -> fwd_hit/fwd_data)
// against results that are queued or being written this cycle.
//
// Ports
//   clk                      single clock, all state updates on posedge
//   rst                      asynchronous, active-low reset
//   alu_valid/alu_ready      ALU result handshake
//   alu_rd/alu_data          ALU destination register and result
//   mem_valid/mem_ready      load-unit result handshake
//   mem_rd/mem_data          load destination register and data
//   dst_reg/dst_reg_data     registered register-file write port
//   reg_write_enable         registered write strobe for the port above
//   fwd_rs                   forwarding query register index
//   fwd_hit/fwd_data         forwarding result (combinational)
//   busy_mask                one bit per register with a write in flight
//   wb_count                 current write-queue occupancy
//
// Handshake: a producer transfer happens on a posedge where valid and
// ready are both high. The producer holds rd/data stable while valid is
// high and ready is low; ready never depends on the same producer's
// valid. The load unit has fixed priority: the ALU is only ready when
// the load unit is not presenting a result, so at most one transfer
// happens per cycle. While rst is low both readies read 1.

module regfile_writeback #(
  parameter int ARCH_LEN     = 32,
  parameter int REG_FILE_LEN = 32,
  parameter int WB_DEPTH     = 4,
  localparam int RW = $clog2(REG_FILE_LEN),
  localparam int PW = $clog2(WB_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [RW-1:0]           alu_rd,
  input  logic [ARCH_LEN-1:0]     alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [RW-1:0]           mem_rd,
  input  logic [ARCH_LEN-1:0]     mem_data,
  output logic [RW-1:0]           dst_reg,
  output logic [ARCH_LEN-1:0]     dst_reg_data,
  output logic                    reg_write_enable,
  input  logic [RW-1:0]           fwd_rs,
  output logic                    fwd_hit,
  output logic [ARCH_LEN-1:0]     fwd_data,
  output logic [REG_FILE_LEN-1:0] busy_mask,
  output logic [CW-1:0]           wb_count
);

  // Write queue storage
  logic [RW-1:0]       q_rd    [WB_DEPTH];
  logic [ARCH_LEN-1:0] q_data  [WB_DEPTH];
  logic [WB_DEPTH-1:0] q_valid;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;

  // Queue slot index ordered by age: age_idx[0] is the oldest slot
  logic [PW-1:0]       age_idx [WB_DEPTH];

  logic                full;
  logic                empty;
  logic                mem_fire;
  logic                alu_fire;
  logic                in_fire;
  logic [RW-1:0]       in_rd;
  logic [ARCH_LEN-1:0] in_data;
  logic                enq;
  logic                deq;

  assign full  = (wb_count == CW'(WB_DEPTH));
  assign empty = (wb_count == '0);

  // Readiness only looks at occupancy before the edge, so a dequeue in the
  // same cycle never frees room for an enqueue.
  assign mem_ready = !rst || !full;
  assign alu_ready = !rst || (!full && !mem_valid);

  assign mem_fire = mem_valid && mem_ready;
  assign alu_fire = alu_valid && alu_ready;
  assign in_fire  = mem_fire || alu_fire;
  assign in_rd    = mem_fire ? mem_rd   : alu_rd;
  assign in_data  = mem_fire ? mem_data : alu_data;

  // Writes to x0 complete the handshake but are dropped here.
  assign enq = in_fire && (in_rd != '0);
  assign deq = !empty;

  // Queue, pointers and the registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
      q_valid          <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      wb_count         <= '0;
      dst_reg          <= '0;
      dst_reg_data     <= '0;
      reg_write_enable <= 1'b0;
    end else begin
      // enq and deq never touch the same slot: wr_ptr == rd_ptr only when
      // the queue is empty (no deq) or full (no enq).
      if (enq) begin
        q_rd[wr_ptr]    <= in_rd;
        q_data[wr_ptr]  <= in_data;
        q_valid[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end

      if (deq) begin
        q_valid[rd_ptr]  <= 1'b0;
        rd_ptr           <= rd_ptr + PW'(1);
        dst_reg          <= q_rd[rd_ptr];
        dst_reg_data     <= q_data[rd_ptr];
        reg_write_enable <= 1'b1;
      end else begin
        // Port address/data hold their last value while idle.
        reg_write_enable <= 1'b0;
      end

      unique case ({enq, deq})
        2'b10:   wb_count <= wb_count + CW'(1);
        2'b01:   wb_count <= wb_count - CW'(1);
        default: wb_count <= wb_count;
      endcase
    end
  end

  // Valid entries are contiguous starting at rd_ptr, so walking forward
  // from rd_ptr visits them oldest first.
  always_comb begin
    for (int a = 0; a < WB_DEPTH; a++) begin
      age_idx[a] = rd_ptr + PW'(a);
    end
  end

  // In-flight destinations: queued entries plus the write being issued.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (q_valid[i]) begin
        busy_mask[q_rd[i]] = 1'b1;
      end
    end
    if (reg_write_enable) begin
      busy_mask[dst_reg] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  // Forwarding: the output stage is the oldest candidate, then queue
  // entries oldest to youngest; a later match overrides an earlier one so
  // the youngest matching result wins. Same-cycle producer inputs are not
  // considered.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rs != '0) begin
      if (reg_write_enable && (dst_reg == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = dst_reg_data;
      end
      for (int a = 0; a < WB_DEPTH; a++) begin
        if (q_valid[age_idx[a]] && (q_rd[age_idx[a]] == fwd_rs)) begin
          fwd_hit  = 1'b1;
          fwd_data = q_data[age_idx[a]];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios followed by randomized
// traffic. A reference model tracks the pending writes as a plain queue
// and predicts ports each cycle; the expected write order is pushed into
// a scoreboard queue on acceptance and popped by a monitor whenever the
// DUT strobes reg_write_enable.

module tb_regfile_writeback;

  localparam int ARCH_LEN     = 32;
  localparam int REG_FILE_LEN = 32;
  localparam int WB_DEPTH     = 4;
  localparam int RW           = $clog2(REG_FILE_LEN);
  localparam int CW           = $clog2(WB_DEPTH) + 1;
  localparam int W            = RW + ARCH_LEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                    alu_valid = 1'b0;
  logic                    alu_ready;
  logic [RW-1:0]           alu_rd = '0;
  logic [ARCH_LEN-1:0]     alu_data = '0;
  logic                    mem_valid = 1'b0;
  logic                    mem_ready;
  logic [RW-1:0]           mem_rd = '0;
  logic [ARCH_LEN-1:0]     mem_data = '0;
  logic [RW-1:0]           dst_reg;
  logic [ARCH_LEN-1:0]     dst_reg_data;
  logic                    reg_write_enable;
  logic [RW-1:0]           fwd_rs = '0;
  logic                    fwd_hit;
  logic [ARCH_LEN-1:0]     fwd_data;
  logic [REG_FILE_LEN-1:0] busy_mask;
  logic [CW-1:0]           wb_count;

  regfile_writeback #(
    .ARCH_LEN    (ARCH_LEN),
    .REG_FILE_LEN(REG_FILE_LEN),
    .WB_DEPTH    (WB_DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_rd          (mem_rd),
    .mem_data        (mem_data),
    .dst_reg         (dst_reg),
    .dst_reg_data    (dst_reg_data),
    .reg_write_enable(reg_write_enable),
    .fwd_rs          (fwd_rs),
    .fwd_hit         (fwd_hit),
    .fwd_data        (fwd_data),
    .busy_mask       (busy_mask),
    .wb_count        (wb_count)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [RW-1:0]       rd;
    logic [ARCH_LEN-1:0] data;
  } wb_t;

  wb_t                 mdl_q[$];        // writes accepted but not yet issued
  logic                mdl_out_valid = 1'b0;
  logic [RW-1:0]       mdl_out_rd    = '0;
  logic [ARCH_LEN-1:0] mdl_out_data  = '0;
  logic [W-1:0]        exp_q[$];        // scoreboard: expected write order

  always @(posedge clk or negedge rst) begin
    bit  room;
    bit  take;
    wb_t acc;
    wb_t head;
    if (!rst) begin
      mdl_q.delete();
      exp_q.delete();
      mdl_out_valid = 1'b0;
      mdl_out_rd    = '0;
      mdl_out_data  = '0;
    end else begin
      room = (mdl_q.size() < WB_DEPTH);
      take = 1'b0;
      acc  = '0;
      if (mem_valid && room) begin
        take = 1'b1;
        acc  = '{rd: mem_rd, data: mem_data};
      end else if (alu_valid && room && !mem_valid) begin
        take = 1'b1;
        acc  = '{rd: alu_rd, data: alu_data};
      end
      if (mdl_q.size() > 0) begin
        head          = mdl_q.pop_front();
        mdl_out_valid = 1'b1;
        mdl_out_rd    = head.rd;
        mdl_out_data  = head.data;
      end else begin
        mdl_out_valid = 1'b0;
      end
      if (take && acc.rd != '0) begin
        mdl_q.push_back(acc);
        exp_q.push_back(acc);
      end
    end
  end

  function automatic logic [REG_FILE_LEN-1:0] mdl_busy();
    logic [REG_FILE_LEN-1:0] m;
    m = '0;
    foreach (mdl_q[i]) m[mdl_q[i].rd] = 1'b1;
    if (mdl_out_valid) m[mdl_out_rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic logic [ARCH_LEN:0] mdl_fwd(input logic [RW-1:0] rs);
    logic                hit;
    logic [ARCH_LEN-1:0] d;
    hit = 1'b0;
    d   = '0;
    if (rs != '0) begin
      if (mdl_out_valid && mdl_out_rd == rs) begin
        hit = 1'b1;
        d   = mdl_out_data;
      end
      foreach (mdl_q[i]) begin
        if (mdl_q[i].rd == rs) begin
          hit = 1'b1;
          d   = mdl_q[i].data;
        end
      end
    end
    return {hit, d};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [ARCH_LEN:0] f;
    logic [W-1:0]      e;
    logic              exp_mr;
    logic              exp_ar;
    if (mon_en) begin
      exp_mr = !rst || (mdl_q.size() < WB_DEPTH);
      exp_ar = !rst || ((mdl_q.size() < WB_DEPTH) && !mem_valid);
      f      = mdl_fwd(fwd_rs);
      check("reg_write_enable", 64'(reg_write_enable), 64'(mdl_out_valid));
      check("dst_reg", 64'(dst_reg), 64'(mdl_out_rd));
      check("dst_reg_data", 64'(dst_reg_data), 64'(mdl_out_data));
      check("wb_count", 64'(wb_count), 64'(mdl_q.size()));
      check("busy_mask", 64'(busy_mask), 64'(mdl_busy()));
      check("mem_ready", 64'(mem_ready), 64'(exp_mr));
      check("alu_ready", 64'(alu_ready), 64'(exp_ar));
      check("fwd_hit", 64'(fwd_hit), 64'(f[ARCH_LEN]));
      check("fwd_data", 64'(fwd_data), 64'(f[ARCH_LEN-1:0]));
      if (reg_write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_write: actual rd=%0d data=0x%0h, expected no write", dst_reg, dst_reg_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_write", 64'({dst_reg, dst_reg_data}), 64'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic mv, input logic [RW-1:0] mrd, input logic [ARCH_LEN-1:0] md,
                        input logic av, input logic [RW-1:0] ard, input logic [ARCH_LEN-1:0] ad,
                        input logic [RW-1:0] frs);
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    fwd_rs    = frs;
  endtask

  task automatic set_idle();
    set_in(1'b0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    step();
    mon_en = 1'b1;

    // Reset state, with both producers requesting
    set_in(1'b1, 5'd2, 32'h1, 1'b1, 5'd3, 32'h2, 5'd2);
    #1;
    check("rst_alu_ready", 64'(alu_ready), 64'(1));
    check("rst_mem_ready", 64'(mem_ready), 64'(1));
    check("rst_wb_count", 64'(wb_count), 64'(0));
    check("rst_rwe", 64'(reg_write_enable), 64'(0));
    check("rst_fwd_hit", 64'(fwd_hit), 64'(0));
    step();
    set_idle();
    step();
    rst = 1'b1;

    // Single ALU write, accepted on the first edge after release
    set_in(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF, '0);
    step();
    check("single_busy5_queued", 64'(busy_mask[5]), 64'(1));
    check("single_rwe_not_yet", 64'(reg_write_enable), 64'(0));
    set_idle();
    step();
    check("single_rwe", 64'(reg_write_enable), 64'(1));
    check("single_dst", 64'(dst_reg), 64'(5));
    check("single_data", 64'(dst_reg_data), 64'(32'hDEADBEEF));
    step();
    check("single_busy_clear", 64'(busy_mask), 64'(0));

    // Priority: mem wins, ALU follows
    set_in(1'b1, 5'd4, 32'hAAAA0004, 1'b1, 5'd3, 32'hBBBB0003, '0);
    #1;
    check("prio_alu_ready", 64'(alu_ready), 64'(0));
    check("prio_mem_ready", 64'(mem_ready), 64'(1));
    step();
    set_in(1'b0, '0, '0, 1'b1, 5'd3, 32'hBBBB0003, '0);
    #1;
    check("prio_alu_ready2", 64'(alu_ready), 64'(1));
    step();
    set_idle();
    check("prio_first_dst", 64'(dst_reg), 64'(4));
    step();
    check("prio_second_dst", 64'(dst_reg), 64'(3));
    step();

    // Write to x0
    set_in(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, '0);
    #1;
    check("x0_mem_ready", 64'(mem_ready), 64'(1));
    step();
    set_idle();
    check("x0_wb_count", 64'(wb_count), 64'(0));
    check("x0_busy", 64'(busy_mask), 64'(0));
    step();
    check("x0_rwe", 64'(reg_write_enable), 64'(0));

    // Back-to-back burst, pointers wrap
    for (int i = 1; i <= 6; i++) begin
      set_in(1'b1, RW'(i), 32'hC0DE0000 + 32'(i), 1'b0, '0, '0, '0);
      step();
      check("burst_le_depth", 64'(wb_count <= CW'(WB_DEPTH)), 64'(1));
    end
    set_idle();
    repeat (3) step();

    // Forwarding picks the youngest write
    set_in(1'b1, 5'd7, 32'h11, 1'b0, '0, '0, '0);
    step();
    set_in(1'b1, 5'd7, 32'h22, 1'b0, '0, '0, '0);
    step();
    set_in(1'b0, '0, '0, 1'b0, '0, '0, 5'd7);
    #1;
    check("fwd7_hit", 64'(fwd_hit), 64'(1));
    check("fwd7_data", 64'(fwd_data), 64'(32'h22));
    fwd_rs = 5'd0;
    #1;
    check("fwd0_hit", 64'(fwd_hit), 64'(0));
    step();
    set_idle();
    repeat (2) step();

    // Reset mid-burst
    for (int i = 8; i <= 10; i++) begin
      set_in(1'b1, RW'(i), 32'hF0000000 + 32'(i), 1'b0, '0, '0, '0);
      step();
    end
    set_idle();
    rst = 1'b0;
    #1;
    check("midrst_rwe", 64'(reg_write_enable), 64'(0));
    check("midrst_wb_count", 64'(wb_count), 64'(0));
    check("midrst_busy", 64'(busy_mask), 64'(0));
    step();
    rst = 1'b1;
    set_in(1'b0, '0, '0, 1'b1, 5'd11, 32'h0B0B, '0);
    step();
    check("post_rst_accept", 64'(wb_count), 64'(1));
    set_idle();
    repeat (3) step();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        set_idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
      end
      set_in($urandom_range(0, 99) < 40, RW'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 99) < 60, RW'($urandom_range(0, 15)), $urandom,
             RW'($urandom_range(0, 15)));
      step();
    end
    set_idle();
    repeat (6) step();
    check("drain_exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL have parameter ARCH_LEN, default 32, register data width.
REQ-002 The block SHALL have parameter REG_FILE_LEN, default 32, number of architectural registers; index width RW = $clog2(REG_FILE_LEN).
REQ-003 The block SHALL have parameter WB_DEPTH, default 4, write-queue entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 alu_valid / alu_ready  input / output  1 / 1  ALU result handshake.
REQ-007 alu_rd / alu_data  input / input  RW / ARCH_LEN  ALU destination register and result.
REQ-008 mem_valid / mem_ready  input / output  1 / 1  load-unit result handshake.
REQ-009 mem_rd / mem_data  input / input  RW / ARCH_LEN  load destination register and data.
REQ-010 dst_reg / dst_reg_data / reg_write_enable  output  RW / ARCH_LEN / 1  register-file write port, all registered.
REQ-011 fwd_rs  input  RW  forwarding query register index.
REQ-012 fwd_hit / fwd_data  output  1 / ARCH_LEN  forwarding result, combinational.
REQ-013 busy_mask  output  REG_FILE_LEN  bit i set while a write to register i is queued or being issued.
REQ-014 wb_count  output  $clog2(WB_DEPTH)+1  current queue occupancy.

Function
REQ-015 A producer transfer SHALL occur on a cycle where valid && ready are both high at posedge clk.
REQ-016 mem_ready SHALL equal !full; alu_ready SHALL equal !full && !mem_valid (mem has fixed priority, at most one transfer per cycle).
REQ-017 full SHALL be wb_count == WB_DEPTH; enqueue is refused when full even if a dequeue occurs that cycle.
REQ-018 A transfer with rd == 0 SHALL complete the handshake but SHALL NOT be enqueued, set busy_mask, or cause a write.
REQ-019 Accepted nonzero-rd entries SHALL enter a circular FIFO; read/write pointers SHALL wrap modulo WB_DEPTH.
REQ-020 Each cycle the FIFO is non-empty, the head entry SHALL be popped and driven into dst_reg/dst_reg_data with reg_write_enable=1 on the next clock edge; otherwise reg_write_enable=0 and dst_reg/dst_reg_data hold their last value.
REQ-021 Latency: entry accepted at edge N into an empty queue SHALL appear with reg_write_enable=1 after edge N+1; throughput one write per cycle.
REQ-022 Writes SHALL be issued in acceptance order; duplicate rd entries are all issued.
REQ-023 Simultaneous enqueue and dequeue SHALL leave wb_count unchanged.
REQ-024 busy_mask bit i SHALL be the OR over valid FIFO entries with rd==i and the output stage when reg_write_enable && dst_reg==i; bit 0 SHALL always be 0.
REQ-025 fwd_hit SHALL be 1 when fwd_rs != 0 and a match exists in the FIFO or output stage; fwd_data SHALL be the youngest match (newest FIFO entry first, then output stage); otherwise fwd_hit=0, fwd_data=0.
REQ-026 Producer inputs in the same cycle SHALL NOT be forwarded (only already-accepted entries).

Reset
REQ-027 While rst=0: pointers and wb_count=0, all FIFO valid bits cleared, reg_write_enable=0, dst_reg=0, dst_reg_data=0, busy_mask=0, fwd_hit=0.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries immediately without issuing them; alu_ready/mem_ready SHALL be 1 while rst=0.
REQ-029 After rst deasserts, the first enqueue SHALL be accepted on the first posedge.

Verification
REQ-030 Single ALU write: alu rd=5 data=0xDEADBEEF at edge 1 -> edge 2 dst_reg=5, dst_reg_data=0xDEADBEEF, reg_write_enable=1; busy_mask[5]=1 between edges 1 and 2, 0 after the write cycle.
REQ-031 Priority: alu rd=3 and mem rd=4 valid together -> mem accepted, alu_ready=0; alu rd=3 accepted next cycle; writes issued 4 then 3.
REQ-032 x0: mem rd=0 data=0x1234 -> mem_ready=1, no reg_write_enable, busy_mask=0, wb_count stays 0.
REQ-033 Full/wrap: stall drain impossible, so burst 6 mem writes rd=1..6 with back-to-back valid -> wb_count never exceeds WB_DEPTH, all 6 issued in order, pointers wrap, no loss.
REQ-034 Forwarding: queue rd=7 data=0x11 then rd=7 data=0x22, fwd_rs=7 -> fwd_hit=1, fwd_data=0x22; fwd_rs=0 -> fwd_hit=0.
REQ-035 Reset mid-burst: 3 entries queued, rst=0 for one cycle -> reg_write_enable=0, wb_count=0, busy_mask=0 immediately; no queued write issued after release.
